multi_sprite_renderer: RTL and testbench
========================================

Name: multi_sprite_renderer

Overview:
Parametrised erase/move/redraw engine for up to N_SPR rectangular sprites on the VGA pixel bus. On each frame tick it visits every enabled sprite in index order. For each one it erases the old footprint with the background colour, applies that sprite's direction inputs with screen-edge clamping, and redraws the sprite, one pixel per cycle. It sits between the game-logic/keyboard direction decode and the vga_adapter plot port, replacing the single-sprite datapath/control pair.

Parameters:
N_SPR, 4, number of sprite channels
SPR_W, 4, sprite width in pixels (>=1)
SPR_H, 4, sprite height in pixels (>=1)
XW, 8, x coordinate width
YW, 7, y coordinate width
X_MAX, 159, rightmost screen column
Y_MAX, 119, bottom screen row
BG_COLOUR, 3'b111, erase colour

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
frame_tick  in  1  one-cycle pulse requesting a frame update
sprite_en  in  N_SPR  per-sprite enable; bit i is sampled when sprite i is visited
init_x  in  N_SPR*XW  reset x per sprite; sprite i uses bits [i*XW +: XW]
init_y  in  N_SPR*YW  reset y per sprite
dir  in  N_SPR*4  per sprite: bit0 right, bit1 up, bit2 down, bit3 left
colour_a  in  N_SPR*3  primary colour
colour_b  in  N_SPR*3  secondary colour
mode  in  N_SPR  0 = solid colour_a; 1 = column checker a/b
vga_x  out  XW  pixel x
vga_y  out  YW  pixel y
vga_colour  out  3  pixel colour
plot  out  1  write strobe; vga_x/vga_y/vga_colour are valid while high
busy  out  1  high from tick acceptance through the last sprite
frame_done  out  1  one-cycle pulse at the end of a frame
overrun  out  1  one-cycle pulse when a frame_tick is dropped

Behaviour:
- Reset is synchronous, active-low, on clk.
  - While resetn=0: state IDLE, pos_x[i]/pos_y[i] <= init_x/init_y, sprite index <= 0.
  - Outputs during reset: plot=0, busy=0, frame_done=0, overrun=0, vga_x=0, vga_y=0, vga_colour=0.
  - Asserting reset mid-frame aborts the frame immediately. No further plot pulses occur.
- All outputs are registered.
- States:
  - IDLE: frame_tick=1 -> SEL with index=0; busy goes high the next cycle.
  - SEL (1 cycle): if sprite_en[index]=1 -> ERASE, else -> NEXT.
  - ERASE (SPR_W*SPR_H cycles): plot=1 with vga_colour=BG_COLOUR at (pos_x+ox, pos_y+oy).
  - MOVE (1 cycle, plot=0): apply dir to the position registers.
  - DRAW (SPR_W*SPR_H cycles): plot=1 at the new position.
  - NEXT (1 cycle): if index=N_SPR-1 -> DONE, else index+1 -> SEL.
  - DONE (1 cycle): frame_done=1 -> IDLE; busy falls the same cycle.
- Scan order in ERASE and DRAW: ox runs 0..SPR_W-1 fastest, then oy runs 0..SPR_H-1. Offset counters reset to 0 on entry to each state.
- Frame length:
  - Enabled sprite: 2*SPR_W*SPR_H+3 cycles (SEL+ERASE+MOVE+DRAW+NEXT).
  - Disabled sprite: 2 cycles.
  - Plus 1 cycle for DONE.
- Move rules:
  - x+1 if right=1, left=0 and pos_x < X_MAX-SPR_W+1.
  - x-1 if left=1, right=0 and pos_x > 0.
  - Right and left both set -> x unchanged.
  - y uses the same rules: down = +1 bounded by Y_MAX-SPR_H+1; up = -1 bounded by 0.
  - No wrap-around. A diagonal move is applied when both axes are legal; a blocked axis does not stop the other.
- DRAW colour:
  - mode[i]=0: colour_a[i].
  - mode[i]=1: colour_a[i] when ox is even, colour_b[i] when ox is odd.
  - mode and colours are sampled per pixel.
- Width handling: coordinate sums are truncated to XW/YW. Clamping keeps the footprint on-screen provided init positions are legal.
- A disabled sprite keeps its position and is neither erased nor drawn.
- frame_tick while busy=1 (including the DONE cycle) is dropped: overrun=1 next cycle, and the frame in progress is unaffected.
- frame_tick in the same cycle that resetn=0 is ignored.

Test Plan:
- Reset with init sprite0=(10,20), all enabled, dir=0, one tick -> 128 plot cycles total. Sprite0 erase pixels run (10,20),(11,20)..(13,23) in colour 111, followed by an identical footprint in colour_a. frame_done pulses once, 4*35+1=141 cycles after busy rises.
- Sprite0 at (156,116), dir=right|down -> position unchanged (clamped). Sprite0 at (0,0), dir=left|up -> unchanged. Sprite0 at (5,5), dir=right|left|down -> position (5,6).
- sprite_en=4'b0101 -> plots only for sprites 0 and 2 (64 plot cycles). Frame length 2*35+2*2+1=75 cycles. Positions of sprites 1 and 3 unchanged.
- mode[0]=1, colour_a=100, colour_b=001 -> draw colours in scan order 100,001,100,001, repeating on every row.
- frame_tick pulsed mid-frame -> overrun pulses 1 cycle later, exactly one frame_done, no extra plots. resetn=0 at cycle 20 of a frame -> plot=0 the next cycle, positions return to init, busy=0.

Source files
------------

// File: rtl/multi_sprite_renderer.sv
// Erase/move/redraw engine for N_SPR rectangular sprites on the VGA plot bus.
// Each frame tick walks the enabled sprites in index order, one pixel per cycle.
//
// state | meaning
// IDLE  | waiting for frame_tick
// SEL   | sample sprite_en for the current index
// ERASE | paint old footprint with BG_COLOUR
// MOVE  | apply clamped direction to the position registers
// DRAW  | paint new footprint with colour_a / checker
// NEXT  | advance index or finish the frame
// DONE  | frame_done pulse, back to IDLE
module multi_sprite_renderer #(
    parameter int         N_SPR     = 4,
    parameter int         SPR_W     = 4,
    parameter int         SPR_H     = 4,
    parameter int         XW        = 8,
    parameter int         YW        = 7,
    parameter int         X_MAX     = 159,
    parameter int         Y_MAX     = 119,
    parameter logic [2:0] BG_COLOUR = 3'b111
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                frame_tick,
    input  logic [N_SPR-1:0]    sprite_en,
    input  logic [N_SPR*XW-1:0] init_x,
    input  logic [N_SPR*YW-1:0] init_y,
    input  logic [N_SPR*4-1:0]  dir,
    input  logic [N_SPR*3-1:0]  colour_a,
    input  logic [N_SPR*3-1:0]  colour_b,
    input  logic [N_SPR-1:0]    mode,
    output logic [XW-1:0]       vga_x,
    output logic [YW-1:0]       vga_y,
    output logic [2:0]          vga_colour,
    output logic                plot,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun
);

    localparam int IW    = (N_SPR > 1) ? $clog2(N_SPR) : 1;
    localparam int OXW   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int OYW   = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int X_LIM = X_MAX - SPR_W + 1;
    localparam int Y_LIM = Y_MAX - SPR_H + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_ERASE, S_MOVE, S_DRAW, S_NEXT, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [OXW-1:0] ox_q, ox_d;
    logic [OYW-1:0] oy_q, oy_d;
    logic [XW-1:0]  pos_x_q [N_SPR];
    logic [XW-1:0]  pos_x_d [N_SPR];
    logic [YW-1:0]  pos_y_q [N_SPR];
    logic [YW-1:0]  pos_y_d [N_SPR];

    logic [XW-1:0]  vga_x_q, vga_x_d;
    logic [YW-1:0]  vga_y_q, vga_y_d;
    logic [2:0]     colour_q, colour_d;
    logic           plot_q, plot_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           overrun_q, overrun_d;

    logic [3:0]     dir_s;
    logic [XW-1:0]  cur_x;
    logic [YW-1:0]  cur_y;

    // Sequencer: next state, scan counters and position update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        dir_s   = dir[int'(idx_q)*4 +: 4];
        cur_x   = pos_x_q[idx_q];
        cur_y   = pos_y_q[idx_q];
        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    state_d = S_SEL;
                    idx_d   = '0;
                end
            end
            S_SEL: begin
                ox_d    = '0;
                oy_d    = '0;
                state_d = sprite_en[idx_q] ? S_ERASE : S_NEXT;
            end
            S_ERASE, S_DRAW: begin
                if (ox_q == OXW'(SPR_W - 1)) begin
                    ox_d = '0;
                    if (oy_q == OYW'(SPR_H - 1)) begin
                        oy_d    = '0;
                        state_d = (state_q == S_ERASE) ? S_MOVE : S_NEXT;
                    end else begin
                        oy_d = oy_q + OYW'(1);
                    end
                end else begin
                    ox_d = ox_q + OXW'(1);
                end
            end
            S_MOVE: begin
                state_d = S_DRAW;
                ox_d    = '0;
                oy_d    = '0;
                // Opposing directions cancel; each axis clamps independently.
                if (dir_s[0] && !dir_s[3] && int'(cur_x) < X_LIM)
                    pos_x_d[idx_q] = cur_x + XW'(1);
                else if (dir_s[3] && !dir_s[0] && cur_x != '0)
                    pos_x_d[idx_q] = cur_x - XW'(1);
                if (dir_s[2] && !dir_s[1] && int'(cur_y) < Y_LIM)
                    pos_y_d[idx_q] = cur_y + YW'(1);
                else if (dir_s[1] && !dir_s[2] && cur_y != '0)
                    pos_y_d[idx_q] = cur_y - YW'(1);
            end
            S_NEXT: begin
                if (idx_q == IW'(N_SPR - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_SEL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output next values derived from next state so registered outputs line up with the state
    always_comb begin
        plot_d    = (state_d == S_ERASE) || (state_d == S_DRAW);
        vga_x_d   = '0;
        vga_y_d   = '0;
        colour_d  = '0;
        if (plot_d) begin
            vga_x_d = pos_x_d[idx_d] + XW'(ox_d);
            vga_y_d = pos_y_d[idx_d] + YW'(oy_d);
            if (state_d == S_ERASE)
                colour_d = BG_COLOUR;
            else if (mode[idx_d] && ox_d[0])
                colour_d = colour_b[int'(idx_d)*3 +: 3];
            else
                colour_d = colour_a[int'(idx_d)*3 +: 3];
        end
        busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
        overrun_d = frame_tick && (state_q != S_IDLE);
    end

    // State, position and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            for (int i = 0; i < N_SPR; i++) begin
                pos_x_q[i] <= init_x[i*XW +: XW];
                pos_y_q[i] <= init_y[i*YW +: YW];
            end
            vga_x_q   <= '0;
            vga_y_q   <= '0;
            colour_q  <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            vga_x_q   <= vga_x_d;
            vga_y_q   <= vga_y_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = colour_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_multi_sprite_renderer.sv
// Directed bench for multi_sprite_renderer: move-rule table plus frame-level sequences.
module tb_multi_sprite_renderer;

    localparam int N_SPR = 4;
    localparam int XW    = 8;
    localparam int YW    = 7;

    logic                clk = 1'b0;
    logic                resetn;
    logic                frame_tick;
    logic [N_SPR-1:0]    sprite_en;
    logic [N_SPR*XW-1:0] init_x;
    logic [N_SPR*YW-1:0] init_y;
    logic [N_SPR*4-1:0]  dir;
    logic [N_SPR*3-1:0]  colour_a;
    logic [N_SPR*3-1:0]  colour_b;
    logic [N_SPR-1:0]    mode;
    logic [XW-1:0]       vga_x;
    logic [YW-1:0]       vga_y;
    logic [2:0]          vga_colour;
    logic                plot;
    logic                busy;
    logic                frame_done;
    logic                overrun;

    multi_sprite_renderer dut (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .sprite_en(sprite_en),
        .init_x(init_x), .init_y(init_y), .dir(dir), .colour_a(colour_a),
        .colour_b(colour_b), .mode(mode), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .plot(plot), .busy(busy), .frame_done(frame_done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // monitor state, sampled on the falling edge
    int cyc = 0, np = 0, nd = 0, nov = 0, rise_cyc = 0, done_cyc = 0;
    logic busy_prev = 1'b0;
    int px [8192];
    int py [8192];
    int pc [8192];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (plot) begin
            if (np < 8192) begin
                px[np] = int'(vga_x);
                py[np] = int'(vga_y);
                pc[np] = int'(vga_colour);
            end
            np = np + 1;
        end
        if (busy && !busy_prev) rise_cyc = cyc;
        busy_prev = busy;
        if (frame_done) begin
            nd = nd + 1;
            done_cyc = cyc;
        end
        if (overrun) nov = nov + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic set_init(input int i, input int x, input int y);
        init_x[i*XW +: XW] = XW'(x);
        init_y[i*YW +: YW] = YW'(y);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) wait_neg();
        resetn = 1'b1;
        wait_neg();
    endtask

    task automatic tick_pulse();
        frame_tick = 1'b1;
        wait_neg();
        frame_tick = 1'b0;
    endtask

    // Pulse a tick and wait (bounded) for the frame to finish.
    task automatic run_frame(output int base, output int plots, output int len);
        int nd0;
        int k;
        base = np;
        nd0  = nd;
        k    = 0;
        tick_pulse();
        while (nd == nd0 && k < 3000) begin
            wait_neg();
            k++;
        end
        repeat (3) wait_neg();
        chk("frame_done_count", nd - nd0, 1);
        plots = np - base;
        len   = done_cyc - rise_cyc + 1;
    endtask

    typedef struct {
        int         x0;
        int         y0;
        logic [3:0] d;
        int         ex;
        int         ey;
    } mv_t;

    mv_t mv [8];

    int base, plots, len, errs, base2;

    initial begin
        // bit0 right, bit1 up, bit2 down, bit3 left
        mv[0] = '{156, 116, 4'b0101, 156, 116};
        mv[1] = '{0,   0,   4'b1010, 0,   0};
        mv[2] = '{5,   5,   4'b1101, 5,   6};
        mv[3] = '{10,  20,  4'b0001, 11,  20};
        mv[4] = '{10,  20,  4'b1010, 9,   19};
        mv[5] = '{156, 50,  4'b0011, 156, 49};
        mv[6] = '{40,  116, 4'b1100, 39,  116};
        mv[7] = '{0,   30,  4'b0110, 0,   30};

        resetn     = 1'b0;
        frame_tick = 1'b1;
        sprite_en  = '1;
        init_x     = '0;
        init_y     = '0;
        dir        = '0;
        colour_a   = {4{3'b010}};
        colour_b   = {4{3'b011}};
        mode       = '0;
        for (int i = 0; i < N_SPR; i++) set_init(i, 10 + 40*i, 20 + 10*i);

        // reset state, tick held during reset must be ignored
        repeat (3) wait_neg();
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_vga", int'({vga_x, vga_y, vga_colour}), 0);
        frame_tick = 1'b0;
        resetn     = 1'b1;
        repeat (2) wait_neg();
        chk("tick_in_reset_ignored", int'(busy), 0);

        // basic frame, all enabled, no movement
        run_frame(base, plots, len);
        chk("frame1_plots", plots, 128);
        chk("frame1_len", len, 141);
        errs = 0;
        for (int k = 0; k < 16; k++) begin
            if (px[base+k] != 10 + k%4 || py[base+k] != 20 + k/4 || pc[base+k] != 7) errs++;
            if (px[base+16+k] != 10 + k%4 || py[base+16+k] != 20 + k/4 || pc[base+16+k] != 2) errs++;
        end
        chk("frame1_sprite0_pixels", errs, 0);
        chk("frame1_sprite3_erase_start", px[base+96]*256 + py[base+96], 130*256 + 50);

        // move-rule table on sprite 0
        for (int v = 0; v < 8; v++) begin
            set_init(0, mv[v].x0, mv[v].y0);
            dir = {12'b0, mv[v].d};
            do_reset();
            run_frame(base, plots, len);
            chk($sformatf("mv%0d_erase_pos", v), px[base]*256 + py[base], mv[v].x0*256 + mv[v].y0);
            chk($sformatf("mv%0d_draw_pos", v), px[base+16]*256 + py[base+16], mv[v].ex*256 + mv[v].ey);
        end

        // sparse enable: sprites 1 and 3 must neither plot nor move
        set_init(0, 10, 20);
        dir = {4{4'b0001}};
        do_reset();
        sprite_en = 4'b0101;
        run_frame(base, plots, len);
        chk("sparse_plots", plots, 64);
        chk("sparse_len", len, 75);
        chk("sparse_sprite2_erase", px[base+32]*256 + py[base+32], 90*256 + 40);
        sprite_en = '1;
        dir = '0;
        run_frame(base, plots, len);
        chk("sparse_sprite0_moved", px[base]*256 + py[base], 11*256 + 20);
        chk("sparse_sprite1_kept", px[base+32]*256 + py[base+32], 50*256 + 30);
        chk("sparse_sprite3_kept", px[base+96]*256 + py[base+96], 130*256 + 50);

        // column checker colours
        do_reset();
        mode = 4'b0001;
        colour_a[2:0] = 3'b100;
        colour_b[2:0] = 3'b001;
        run_frame(base, plots, len);
        errs = 0;
        for (int k = 0; k < 16; k++)
            if (pc[base+16+k] != ((k % 2 == 0) ? 4 : 1)) errs++;
        chk("checker_colours", errs, 0);
        chk("checker_sprite1_solid", pc[base+48], 2);
        mode = '0;

        // dropped tick mid-frame
        do_reset();
        base2 = np;
        begin
            int nd0, nov0, k;
            nd0  = nd;
            nov0 = nov;
            tick_pulse();
            repeat (30) wait_neg();
            tick_pulse();
            chk("overrun_next_cycle", int'(overrun), 1);
            k = 0;
            while (nd == nd0 && k < 3000) begin
                wait_neg();
                k++;
            end
            repeat (20) wait_neg();
            chk("overrun_one_done", nd - nd0, 1);
            chk("overrun_pulse_count", nov - nov0, 1);
            chk("overrun_plots", np - base2, 128);
            chk("overrun_idle_after", int'(busy), 0);
        end

        // reset mid-frame after sprite 0 has already moved
        set_init(0, 10, 20);
        dir = {12'b0, 4'b0001};
        do_reset();
        tick_pulse();
        repeat (20) wait_neg();
        resetn = 1'b0;
        wait_neg();
        chk("abort_plot", int'(plot), 0);
        chk("abort_busy", int'(busy), 0);
        base2 = np;
        repeat (5) wait_neg();
        chk("abort_no_plots", np - base2, 0);
        resetn = 1'b1;
        dir = '0;
        wait_neg();
        run_frame(base, plots, len);
        chk("abort_pos_restored", px[base]*256 + py[base], 10*256 + 20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
